// File: rtl/bkgnd_pkg.sv
// ---------------------------------------------------------------------------
// bkgnd_pkg
//   Shared definitions for the background restore read path. It holds the
//   screen geometry, the coordinate/address/colour widths and the reader FSM
//   state encoding.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package bkgnd_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int ADDR_W = 15;
    localparam int COL_W  = 3;
    localparam int SIZE_W = 5;

    localparam logic [COL_W-1:0] TRANSPARENT_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// ---------------------------------------------------------------------------
// rect_scan_counter
//   Raster-order offset counter for a rectangular region. The x offset is the
//   inner loop and the y offset is the outer loop. It produces absolute pixel
//   coordinates, a last-pixel flag and an off-screen (clip) flag.
//   Ports:
//     clock, reset   system clock, synchronous active-high reset
//     load           latch origin/size and clear offsets
//     xorg, yorg     region origin
//     w, h           region size (non-zero when stepping)
//     step           advance to the next pixel in raster order
//     px, py         absolute coordinates of the current pixel (widened)
//     last           current pixel is the final one of the region
//     clip           current pixel lies outside the screen
// ---------------------------------------------------------------------------
module rect_scan_counter
    import bkgnd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [X_W-1:0]    xorg,
    input  logic [Y_W-1:0]    yorg,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    input  logic              step,
    output logic [X_W:0]      px,
    output logic [Y_W:0]      py,
    output logic              last,
    output logic              clip
);

    logic [X_W-1:0]    xorg_q;
    logic [Y_W-1:0]    yorg_q;
    logic [SIZE_W-1:0] w_q;
    logic [SIZE_W-1:0] h_q;
    logic [SIZE_W-1:0] xoff;
    logic [SIZE_W-1:0] yoff;
    logic              x_end;
    logic              y_end;

    assign x_end = (xoff + 5'd1) == w_q;
    assign y_end = (yoff + 5'd1) == h_q;
    assign last  = x_end && y_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            xorg_q <= '0;
            yorg_q <= '0;
            w_q    <= '0;
            h_q    <= '0;
            xoff   <= '0;
            yoff   <= '0;
        end else if (load) begin
            xorg_q <= xorg;
            yorg_q <= yorg;
            w_q    <= w;
            h_q    <= h;
            xoff   <= '0;
            yoff   <= '0;
        end else if (step) begin
            if (x_end) begin
                xoff <= '0;
                yoff <= yoff + 5'd1;
            end else begin
                xoff <= xoff + 5'd1;
            end
        end
    end

    // Sums are one bit wider than the screen coordinates so that a region
    // hanging past the right/bottom edge is detected rather than wrapping.
    assign px   = {1'b0, xorg_q} + {4'b0, xoff};
    assign py   = {1'b0, yorg_q} + {3'b0, yoff};
    assign clip = (px >= 9'(SCREEN_W)) || (py >= 8'(SCREEN_H));

endmodule

// File: rtl/bkgnd_restore_reader.sv
// ---------------------------------------------------------------------------
// bkgnd_restore_reader
//   Reads a rectangle of the stored background out of the frame memory and
//   streams it as (x, y, colour) plot requests over a valid/ready handshake.
//   It restores the background behind a sprite that has moved. Off-screen
//   pixels are skipped without a memory read.
//   Optional feature macro: BKGND_READ_TRANSPARENT_EN. When defined, pixels
//   whose stored colour equals TRANSPARENT_COLOUR are read but not emitted.
//   Ports:
//     clock, reset          system clock, synchronous active-high reset
//     start                 begin a region read (sampled in IDLE only)
//     xPosition, yPosition  region origin, latched on accepted start
//     width, height         region size 0..16, latched on accepted start
//     busy                  region in progress (READ..DONE)
//     done                  one-cycle completion pulse
//     mem_addr, mem_rden    frame memory read request
//     mem_q                 frame memory data, valid one cycle after request
//     x, y, colourOut       current plot request
//     plot, plot_ready      plot request valid / downstream accept
// ---------------------------------------------------------------------------
module bkgnd_restore_reader
    import bkgnd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    xPosition,
    input  logic [Y_W-1:0]    yPosition,
    input  logic [SIZE_W-1:0] width,
    input  logic [SIZE_W-1:0] height,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [COL_W-1:0]  mem_q,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [COL_W-1:0]  colourOut,
    output logic              plot,
    input  logic              plot_ready
);

    state_t         state;
    state_t         next_state;
    logic           load;
    logic           step;
    logic [X_W:0]   px;
    logic [Y_W:0]   py;
    logic           last;
    logic           clip;

    assign load = (state == S_IDLE) && start;

    rect_scan_counter u_scan (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .xorg  (xPosition),
        .yorg  (yPosition),
        .w     (width),
        .h     (height),
        .step  (step),
        .px    (px),
        .py    (py),
        .last  (last),
        .clip  (clip)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = ((width == '0) || (height == '0)) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (clip) begin
                    step       = 1'b1;
                    next_state = last ? S_DONE : S_READ;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef BKGND_READ_TRANSPARENT_EN
                if (mem_q == TRANSPARENT_COLOUR) begin
                    step       = 1'b1;
                    next_state = last ? S_DONE : S_READ;
                end else begin
                    next_state = S_EMIT;
                end
`else
                next_state = S_EMIT;
`endif
            end
            S_EMIT: begin
                if (plot_ready) begin
                    step       = 1'b1;
                    next_state = last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Plot payload is captured once in WAIT and only changes there, so it is
    // held steady for the whole of EMIT regardless of backpressure.
    always_ff @(posedge clock) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            colourOut <= '0;
        end else if (state == S_WAIT) begin
            x         <= px[X_W-1:0];
            y         <= py[Y_W-1:0];
            colourOut <= mem_q;
        end
    end

    // py*160 + px built from shifts: 160 = 128 + 32.
    assign mem_addr = {py, 7'b0} + {2'b0, py, 5'b0} + {6'b0, px};
    assign mem_rden = (state == S_READ) && !clip;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign plot = (state == S_EMIT);

endmodule

// File: tb/tb_bkgnd_restore_reader.sv
module tb_bkgnd_restore_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  xPosition;
    logic [6:0]  yPosition;
    logic [4:0]  width;
    logic [4:0]  height;
    logic        busy;
    logic        done;
    logic [14:0] mem_addr;
    logic        mem_rden;
    logic [2:0]  mem_q;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colourOut;
    logic        plot;
    logic        plot_ready;

    int total = 0;
    int bad   = 0;

    logic [2:0] mem [0:19199];

`ifdef BKGND_READ_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    bkgnd_restore_reader dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .xPosition  (xPosition),
        .yPosition  (yPosition),
        .width      (width),
        .height     (height),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rden   (mem_rden),
        .mem_q      (mem_q),
        .x          (x),
        .y          (y),
        .colourOut  (colourOut),
        .plot       (plot),
        .plot_ready (plot_ready)
    );

    always #5 clock = ~clock;

    // Synchronous-read frame memory; junk data on cycles without a read.
    always @(posedge clock) begin
        if (mem_rden && (mem_addr < 15'd19200)) mem_q <= mem[mem_addr];
        else                                    mem_q <= 3'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic run_region(input string name, input int x0, input int y0,
                              input int w, input int h, input int stall_pct,
                              input int hold_first);
        int ea[$];
        int ex[$];
        int ey[$];
        int ec[$];
        int n_clip = 0;
        int n_emit = 0;
        int n_skip = 0;
        int cyc = 0;
        int stalls = 0;
        int reads = 0;
        int emits = 0;
        int plot_hi = 0;
        int hold = hold_first;
        bit fin = 1'b0;
        bit stalled = 1'b0;
        logic [7:0] sx = '0;
        logic [6:0] sy = '0;
        logic [2:0] sc = '0;

        for (int yo = 0; yo < h; yo++) begin
            for (int xo = 0; xo < w; xo++) begin
                int pxv = x0 + xo;
                int pyv = y0 + yo;
                if (pxv >= 160 || pyv >= 120) begin
                    n_clip++;
                end else begin
                    int a = pyv * 160 + pxv;
                    ea.push_back(a);
                    if (TRANSP && mem[a] == 3'b000) begin
                        n_skip++;
                    end else begin
                        n_emit++;
                        ex.push_back(pxv);
                        ey.push_back(pyv);
                        ec.push_back(int'(mem[a]));
                    end
                end
            end
        end

        @(negedge clock);
        start      = 1'b1;
        xPosition  = 8'(x0);
        yPosition  = 7'(y0);
        width      = 5'(w);
        height     = 5'(h);
        plot_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (!fin && cyc < 3000) begin
            chk({name, ".busy"}, 32'(busy), 32'd1);
            if (stalled) begin
                chk({name, ".stall_plot"}, 32'(plot), 32'd1);
                chk({name, ".stall_x"}, 32'(x), 32'(sx));
                chk({name, ".stall_y"}, 32'(y), 32'(sy));
                chk({name, ".stall_c"}, 32'(colourOut), 32'(sc));
                chk({name, ".stall_rden"}, 32'(mem_rden), 32'd0);
            end
            if (mem_rden) begin
                reads++;
                if (ea.size() == 0) chk({name, ".extra_read"}, 32'd1, 32'd0);
                else                chk({name, ".addr"}, 32'(mem_addr), 32'(ea.pop_front()));
            end
            if (done) begin
                fin = 1'b1;
                chk({name, ".done_cycle"}, 32'(cyc),
                    32'(1 + 3 * n_emit + 2 * n_skip + n_clip + stalls));
                chk({name, ".done_plot"}, 32'(plot), 32'd0);
            end else begin
                if (plot && hold > 0) begin
                    plot_ready = 1'b0;
                    hold--;
                end else begin
                    plot_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                if (plot) plot_hi++;
                if (plot && plot_ready) begin
                    emits++;
                    if (ex.size() == 0) begin
                        chk({name, ".extra_plot"}, 32'd1, 32'd0);
                    end else begin
                        chk({name, ".x"}, 32'(x), 32'(ex.pop_front()));
                        chk({name, ".y"}, 32'(y), 32'(ey.pop_front()));
                        chk({name, ".colour"}, 32'(colourOut), 32'(ec.pop_front()));
                    end
                end
                stalled = plot && !plot_ready;
                if (stalled) begin
                    stalls++;
                    sx = x;
                    sy = y;
                    sc = colourOut;
                end
                @(negedge clock);
                cyc++;
            end
        end
        if (!fin) chk({name, ".timeout"}, 32'd0, 32'd1);
        chk({name, ".reads"}, 32'(reads), 32'(n_emit + n_skip));
        chk({name, ".emits"}, 32'(emits), 32'(n_emit));
        chk({name, ".plot_cycles"}, 32'(plot_hi), 32'(n_emit + stalls));
        if (stall_pct == 0 && n_emit > 0) chk({name, ".stalls"}, 32'(stalls), 32'(hold_first));
        plot_ready = 1'b1;
        @(negedge clock);
        chk({name, ".post_done"}, 32'(done), 32'd0);
        chk({name, ".post_busy"}, 32'(busy), 32'd0);
        chk({name, ".post_plot"}, 32'(plot), 32'd0);
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        start      = 1'b0;
        xPosition  = '0;
        yPosition  = '0;
        width      = '0;
        height     = '0;
        plot_ready = 1'b1;
        for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
        mem[20 * 160 + 20] = 3'b101;
        mem[20 * 160 + 21] = 3'b000;
        mem[20 * 160 + 22] = 3'b011;

        repeat (3) @(negedge clock);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.plot", 32'(plot), 32'd0);
        chk("rst.rden", 32'(mem_rden), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        chk("rst.xyc", {8'(x), 8'(y), 16'(colourOut)}, 32'd0);
        reset = 1'b0;

        run_region("r2x2", 10, 5, 2, 2, 0, 0);
        run_region("bp2x2", 10, 5, 2, 2, 0, 5);
        run_region("clip4x3", 158, 119, 4, 3, 0, 0);
        run_region("zero_w", 30, 30, 0, 5, 0, 0);
        run_region("transp3x1", 20, 20, 3, 1, 0, 0);

        // Reset while a plot request is pending.
        @(negedge clock);
        start      = 1'b1;
        xPosition  = 8'd10;
        yPosition  = 7'd5;
        width      = 5'd2;
        height     = 5'd2;
        plot_ready = 1'b0;
        @(negedge clock);
        start  = 1'b0;
        waited = 0;
        while (!plot && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        chk("midrst.plot_seen", 32'(plot), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst.plot", 32'(plot), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.rden", 32'(mem_rden), 32'd0);
        chk("midrst.addr", 32'(mem_addr), 32'd0);
        chk("midrst.xyc", {8'(x), 8'(y), 16'(colourOut)}, 32'd0);
        reset      = 1'b0;
        plot_ready = 1'b1;
        run_region("post_rst1x1", 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_region("rand", $urandom_range(0, 170), $urandom_range(0, 127),
                       $urandom_range(0, 16), $urandom_range(0, 16), 30, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bkgnd_restore_reader.md
# bkgnd_restore_reader

Reads a rectangular region of the stored background image out of the background frame memory and streams it, one pixel at a time, as (x, y, colour) plot requests to the VGA plotter path. It is the read-side counterpart of the background draw path. It restores the background behind a sprite that has moved. A plotter/arbiter downstream drains the stream using a valid/ready handshake.

## Interface
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- TRANSPARENT_COLOUR, 3'b000, colour value skipped when the transparency feature is compiled in.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a region read; sampled only in IDLE.
- xPosition  in  8  region origin x, latched on accepted start.
- yPosition  in  7  region origin y, latched on accepted start.
- width  in  5  region width, 0..16, latched on accepted start.
- height  in  5  region height, 0..16, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through DONE.
- done  out  1  one-cycle pulse when the region is finished.
- mem_addr  out  15  frame memory read address.
- mem_rden  out  1  frame memory read enable.
- mem_q  in  3  frame memory read data; valid the cycle after mem_addr/mem_rden.
- x  out  8  pixel x of the current plot request.
- y  out  7  pixel y of the current plot request.
- colourOut  out  3  pixel colour of the current plot request.
- plot  out  1  plot request valid.
- plot_ready  in  1  downstream accepts the request when plot and plot_ready are both high.

## Operation
- FSM states:
  - IDLE: waits for start. A start with width=0 or height=0 goes straight to DONE.
  - READ: if the current pixel is on-screen, drives mem_addr and asserts mem_rden, then goes to WAIT. If it is off-screen, it advances the offset counters without reading and stays in READ, or goes to DONE after the last pixel.
  - WAIT: captures mem_q into colourOut.
  - EMIT: holds plot high until the handshake completes, then goes to READ, or to DONE after the last pixel.
  - DONE: done=1 for one cycle, then IDLE.
- Scan order is raster: x offset inner (0..width-1), y offset outer (0..height-1).
- Pixel coordinates: px = xPosition + xoff (9-bit sum), py = yPosition + yoff (8-bit sum). A pixel is clipped when px >= SCREEN_W or py >= SCREEN_H. Clipped pixels are never read and never emitted.
- mem_addr = py*SCREEN_W + px, truncated to 15 bits. For SCREEN_W=160 this is implemented as (py<<7)+(py<<5)+px, with no multiplier.
- x, y and colourOut must stay stable while plot=1 and plot_ready=0.
- start is ignored while busy=1, and in DONE.
- Reset values: busy=0, done=0, plot=0, mem_rden=0, mem_addr=0, x=0, y=0, colourOut=0, state=IDLE, offsets=0.
- reset asserted in any state: the next cycle is IDLE with all outputs at their reset values. An in-flight plot is dropped, not completed.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: READ, busy=1, first address issued.
- Cycle 2: WAIT.
- Cycle 3: first plot=1.
- Unstalled throughput: one on-screen pixel per 3 cycles.
- Each clipped pixel costs 1 cycle.
- done pulses in the cycle after the final handshake, or after the final clipped skip.
- Zero-size region: done=1 in cycle 1, and plot is never asserted.
- mem_rden is asserted for exactly one cycle per on-screen pixel.

## Configuration
- BKGND_READ_TRANSPARENT_EN defined: a pixel whose mem_q equals TRANSPARENT_COLOUR is read but not emitted. WAIT then goes directly to READ, or to DONE after the last pixel. A skipped pixel costs 2 cycles.
- BKGND_READ_TRANSPARENT_EN undefined: every on-screen pixel is emitted. TRANSPARENT_COLOUR is unused.

## Structure
- Shared package bkgnd_pkg holds:
  - SCREEN_W, SCREEN_H;
  - coordinate widths: 8-bit x, 7-bit y, 15-bit address, 3-bit colour;
  - the FSM state enum.
- One sub-module, rect_scan_counter: xoff/yoff counters with last-pixel and clip flags, advanced by a single step input.

## Test plan
- Region 2x2 at (10,5), plot_ready=1: mem_addr is issued as 810, 811, 970, 971. Plots are emitted at (10,5), (11,5), (10,6), (11,6) with the returned colours. Then one done pulse, busy=0.
- Backpressure on the same region: plot_ready=0 for 5 cycles on the first pixel. plot stays high, x/y/colourOut stay stable, and no new mem_rden is asserted. On release the remaining pixels follow normally.
- Clipping, 4x3 at (158,119): only (158,119) and (159,119) are read and emitted, exactly 2 mem_rden pulses, then done.
- width=0, height=5: done=1 in the cycle after start, plot never high, mem_rden never high.
- reset asserted while plot=1 mid-region: the next cycle has plot=0, busy=0 and all outputs zero. A new 1x1 start at (0,0) then reads address 0 and emits (0,0).
- With BKGND_READ_TRANSPARENT_EN, 3x1 at (20,20), mem_q returning 3'b101, 3'b000, 3'b011: only (20,20) colour 5 and (22,20) colour 3 are emitted.
